// File: rtl/cachable_regions_pkg.sv
// cachable_regions_pkg: shared sizing, FSM encoding and INIT-vector slicing for cachable_regions.
package cachable_regions_pkg;

   localparam int MAX_AW  = 64;
   localparam int MAX_VEC = 16 * MAX_AW;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   function automatic int iw_of(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Callers zero-extend the packed INIT vector to MAX_VEC and truncate the result to AW.
   function automatic logic [MAX_AW-1:0] entry_of(input logic [MAX_VEC-1:0] v, input int aw, input int i);
      return MAX_AW'(v >> (i * aw));
   endfunction

endpackage

// File: rtl/cachable_regions_region_match.sv
// region_match: single-entry enable and base/mask compare for the cachable region table.
module region_match #(
   parameter int AW = 28
) (
   input  logic [AW-1:0] i_addr,
   input  logic [AW-1:0] i_base,
   input  logic [AW-1:0] i_mask,
   output logic          o_hit
);

   assign o_hit = (i_base != '0) && ((i_addr & i_mask) == i_base);

endmodule

// File: rtl/cachable_regions.sv
// cachable_regions: programmable base/mask cachable-region table with registered lookups,
// lockable entries and a flush handshake raised whenever the region map changes.
module cachable_regions
   import cachable_regions_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 28,
   parameter int NREGIONS      = 4,
   parameter logic [NREGIONS*ADDRESS_WIDTH-1:0] INIT_ADDR =
      {{(NREGIONS*ADDRESS_WIDTH-2){1'b0}}, 2'b01} << (ADDRESS_WIDTH-2),
   parameter logic [NREGIONS*ADDRESS_WIDTH-1:0] INIT_MASK =
      {{(NREGIONS*ADDRESS_WIDTH-2){1'b0}}, 2'b11} << (ADDRESS_WIDTH-2),
   parameter bit OPT_LOCK = 1'b1
) (
   input  logic                          i_clk,
   input  logic                          i_reset_n,
   input  logic                          i_cfg_we,
   input  logic [iw_of(NREGIONS)-1:0]    i_cfg_idx,
   input  logic [ADDRESS_WIDTH-1:0]      i_cfg_addr,
   input  logic [ADDRESS_WIDTH-1:0]      i_cfg_mask,
   input  logic                          i_cfg_lock,
   output logic                          o_cfg_err,
   input  logic                          i_lkup_stb,
   input  logic [ADDRESS_WIDTH-1:0]      i_lkup_addr,
   output logic                          o_lkup_busy,
   output logic                          o_lkup_valid,
   output logic                          o_cachable,
   output logic [iw_of(NREGIONS)-1:0]    o_region,
   output logic                          o_flush_req,
   input  logic                          i_flush_ack
);

   localparam int AW = ADDRESS_WIDTH;
   localparam int IW = iw_of(NREGIONS);

   logic [AW-1:0]       base_q [NREGIONS];
   logic [AW-1:0]       mask_q [NREGIONS];
   logic                lock_q [NREGIONS];
   logic [NREGIONS-1:0] hit, sel, diff, locked;
   state_e              state_q, state_d;
   logic                busy, lkup_acc, wr_ok, any_hit;
   logic [IW-1:0]       hit_idx;
   logic                valid_q, cachable_q, err_q;
   logic [IW-1:0]       region_q;

   for (genvar i = 0; i < NREGIONS; i++) begin : g_entry
      region_match #(.AW(AW)) u_match (
         .i_addr (i_lkup_addr),
         .i_base (base_q[i]),
         .i_mask (mask_q[i]),
         .o_hit  (hit[i])
      );
      assign sel[i]    = i_cfg_idx == IW'(i);
      assign diff[i]   = (base_q[i] != i_cfg_addr) || (mask_q[i] != i_cfg_mask);
      assign locked[i] = sel[i] && lock_q[i];
      // Only unlocked entries accept writes, so the new lock bit never needs to OR in the old one.
      always_ff @(posedge i_clk or negedge i_reset_n)
         if (!i_reset_n) begin
            base_q[i] <= AW'(entry_of(MAX_VEC'(INIT_ADDR), AW, i));
            mask_q[i] <= AW'(entry_of(MAX_VEC'(INIT_MASK), AW, i));
            lock_q[i] <= 1'b0;
         end else if (wr_ok && sel[i]) begin
            base_q[i] <= i_cfg_addr;
            mask_q[i] <= i_cfg_mask;
            lock_q[i] <= i_cfg_lock && OPT_LOCK;
         end
   end

   // Lowest-index hit wins; no hit leaves the index at zero.
   always_comb begin
      hit_idx = '0;
      for (int k = NREGIONS - 1; k >= 0; k--)
         if (hit[k]) hit_idx = IW'(k);
   end

   assign any_hit  = |hit;
   assign lkup_acc = i_lkup_stb && !busy;
   assign wr_ok    = i_cfg_we && !busy && (|sel) && !(|locked);

   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) state_q <= ST_IDLE;
      else            state_q <= state_d;

   always_comb begin
      state_d = (state_q == ST_IDLE) ? ((wr_ok && |(sel & diff)) ? ST_FLUSH : ST_IDLE)
                                     : (i_flush_ack ? ST_IDLE : ST_FLUSH);
   end

   always_comb begin
      busy        = state_q == ST_FLUSH;
      o_lkup_busy = busy;
      o_flush_req = busy;
   end

   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         valid_q    <= 1'b0;
         cachable_q <= 1'b0;
         region_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         valid_q <= lkup_acc;
         err_q   <= i_cfg_we && !wr_ok;
         if (lkup_acc) begin
            cachable_q <= any_hit;
            region_q   <= hit_idx;
         end
      end

   assign o_lkup_valid = valid_q;
   assign o_cachable   = cachable_q;
   assign o_region     = region_q;
   assign o_cfg_err    = err_q;

endmodule

// File: tb/tb_cachable_regions.sv
// tb_cachable_regions: directed scoreboard bench for cachable_regions (default and 3-entry/no-lock builds).
module tb_cachable_regions;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        we = 1'b0, we2 = 1'b0, clk_lock = 1'b0;
   logic [1:0]  idx = '0;
   logic [27:0] caddr = '0, cmask = '0, laddr = '0;
   logic        stb = 1'b0, ack = 1'b0, ack2 = 1'b0;
   logic        err, busy, valid, cach, freq;
   logic [1:0]  region;
   logic        err2, busy2, valid2, cach2, freq2;
   logic [1:0]  region2;
   int          checks = 0, errors = 0;
   logic [2:0]  sb[$];
   logic [2:0]  exp_r;

   always #5 clk = ~clk;

   cachable_regions dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_cfg_we(we), .i_cfg_idx(idx),
      .i_cfg_addr(caddr), .i_cfg_mask(cmask), .i_cfg_lock(clk_lock), .o_cfg_err(err),
      .i_lkup_stb(stb), .i_lkup_addr(laddr), .o_lkup_busy(busy), .o_lkup_valid(valid),
      .o_cachable(cach), .o_region(region), .o_flush_req(freq), .i_flush_ack(ack)
   );

   cachable_regions #(.NREGIONS(3), .OPT_LOCK(1'b0)) dut2 (
      .i_clk(clk), .i_reset_n(rst_n), .i_cfg_we(we2), .i_cfg_idx(idx),
      .i_cfg_addr(caddr), .i_cfg_mask(cmask), .i_cfg_lock(clk_lock), .o_cfg_err(err2),
      .i_lkup_stb(1'b0), .i_lkup_addr(laddr), .o_lkup_busy(busy2), .o_lkup_valid(valid2),
      .o_cachable(cach2), .o_region(region2), .o_flush_req(freq2), .i_flush_ack(ack2)
   );

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", n, a, e);
      end
   endtask

   task automatic chk_st(input string n, input logic f, input logic b, input logic e);
      chk({n, "_flush"}, 32'(freq), 32'(f));
      chk({n, "_busy"},  32'(busy), 32'(b));
      chk({n, "_err"},   32'(err),  32'(e));
   endtask

   task automatic chk_rst_outputs(input string n);
      chk({n, "_valid"}, 32'(valid), 0);
      chk({n, "_cach"},  32'(cach),  0);
      chk({n, "_region"}, 32'(region), 0);
      chk_st(n, 1'b0, 1'b0, 1'b0);
   endtask

   always @(negedge clk)
      if (valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected got=%b want=none", {cach, region});
         end else begin
            exp_r = sb.pop_front();
            chk("lkup_result", 32'({cach, region}), 32'(exp_r));
         end
      end

   task automatic lookup(input logic [27:0] a, input logic c, input logic [1:0] r);
      int   n = 0;
      logic acc;
      sb.push_back({c, r});
      stb   = 1'b1;
      laddr = a;
      do begin
         acc = !busy;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 50);
      stb = 1'b0;
      chk("lkup_accept", 32'(acc), 1);
   endtask

   task automatic cfg(input bit d2, input logic [1:0] i, input logic [27:0] a, input logic [27:0] m, input logic l);
      idx = i; caddr = a; cmask = m; clk_lock = l;
      if (d2) we2 = 1'b1;
      else    we  = 1'b1;
      @(posedge clk); #1;
      we = 1'b0; we2 = 1'b0; clk_lock = 1'b0;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      chk("ack_busy", 32'(busy), 0);
   endtask

   task automatic do_ack2();
      ack2 = 1'b1;
      @(posedge clk); #1;
      ack2 = 1'b0;
      chk("ack2_busy", 32'(busy2), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk); #1;
      chk_rst_outputs("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;
      lookup(28'h4000123, 1'b1, 2'd0);
      lookup(28'hC000000, 1'b0, 2'd0);
      lookup(28'h0000000, 1'b0, 2'd0);
      // Program entry 1; a lookup held during FLUSH is only taken the cycle after ack.
      cfg(0, 2'd1, 28'h8000000, 28'hC000000, 1'b0);
      chk_st("prog1", 1'b1, 1'b1, 1'b0);
      stb = 1'b1; laddr = 28'h8000010; sb.push_back(3'b101);
      repeat (2) begin
         @(posedge clk); #1;
         chk("flush_hold_valid", 32'(valid), 0);
      end
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      chk_st("ack1", 1'b0, 1'b0, 1'b0);
      chk("ack1_valid", 32'(valid), 0);
      @(posedge clk); #1;
      stb = 1'b0;
      chk("post_ack_valid", 32'(valid), 1);
      lookup(28'h8000010, 1'b1, 2'd1);
      // Overlap and identical rewrite; a write while busy is rejected.
      cfg(0, 2'd0, 28'h4000000, 28'hC000000, 1'b0);
      chk_st("same0", 1'b0, 1'b0, 1'b0);
      cfg(0, 2'd2, 28'h4000000, 28'hF000000, 1'b0);
      chk_st("prog2", 1'b1, 1'b1, 1'b0);
      cfg(0, 2'd3, 28'h1000000, 28'hF000000, 1'b0);
      chk_st("busy_wr", 1'b1, 1'b1, 1'b1);
      do_ack();
      lookup(28'h4000000, 1'b1, 2'd0);
      lookup(28'h1000000, 1'b0, 2'd0);
      // Same-cycle lookup and write: lookup sees the old table.
      stb = 1'b1; laddr = 28'h8000000; sb.push_back(3'b101);
      cfg(0, 2'd1, 28'h0, 28'hC000000, 1'b0);
      stb = 1'b0;
      chk_st("same_cyc", 1'b1, 1'b1, 1'b0);
      do_ack();
      lookup(28'h8000000, 1'b0, 2'd0);
      // Lock entry 1, then a rewrite is rejected with a single err pulse.
      cfg(0, 2'd1, 28'h8000000, 28'hC000000, 1'b1);
      chk_st("lock_wr", 1'b1, 1'b1, 1'b0);
      do_ack();
      cfg(0, 2'd1, 28'h0, 28'hC000000, 1'b0);
      chk_st("locked_wr", 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      chk("err_pulse", 32'(err), 0);
      lookup(28'h8000000, 1'b1, 2'd1);
      // Reset in the middle of a flush.
      cfg(0, 2'd3, 28'h1000000, 28'hF000000, 1'b0);
      chk_st("prog3", 1'b1, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk_rst_outputs("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         chk_st("post_rst", 1'b0, 1'b0, 1'b0);
      end
      lookup(28'h1000000, 1'b0, 2'd0);
      lookup(28'h8000010, 1'b0, 2'd0);
      lookup(28'h4000123, 1'b1, 2'd0);
      cfg(0, 2'd1, 28'h8000000, 28'hC000000, 1'b0);
      chk_st("unlock", 1'b1, 1'b1, 1'b0);
      do_ack();
      // Three-entry build without locking.
      cfg(1, 2'd3, 28'h1000000, 28'hF000000, 1'b0);
      chk("d2_idx_err", 32'(err2), 1);
      chk("d2_idx_flush", 32'(freq2), 0);
      cfg(1, 2'd1, 28'h8000000, 28'hC000000, 1'b1);
      chk("d2_lock_err", 32'(err2), 0);
      chk("d2_lock_flush", 32'(freq2), 1);
      do_ack2();
      cfg(1, 2'd1, 28'h0, 28'hC000000, 1'b0);
      chk("d2_nolock_err", 32'(err2), 0);
      chk("d2_nolock_flush", 32'(freq2), 1);
      do_ack2();
      repeat (3) @(posedge clk); #1;
      chk("sb_drain", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
